// File: rtl/execute_pkg.sv
// Shared types and helpers for the execute-stage load/store unit.
package execute_pkg;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_STOR = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_W = 2'd1,
    SIZE_D = 2'd2,
    SIZE_Q = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Number of byte lanes in one memory data word.
  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/execute_load_store_lane_align.sv
// Byte-lane steering: split detection, byte enables, write data
// positioning and load data assembly with extension.
module lsu_lane_align
  import execute_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
  input  size_t                           size,
  input  logic                            sign_ext,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH-1:0]           rdata0,
  input  logic [DATA_WIDTH-1:0]           rdata1,
  output logic                            split,
  output logic [DATA_WIDTH/8-1:0]         be0,
  output logic [DATA_WIDTH/8-1:0]         be1,
  output logic [DATA_WIDTH-1:0]           wdata0,
  output logic [DATA_WIDTH-1:0]           wdata1,
  output logic [DATA_WIDTH-1:0]           load_data
);

  localparam int LANES = lanes_of(DATA_WIDTH);

  int                    offset;
  int                    nbytes;
  int                    src;
  logic [DATA_WIDTH-1:0] assembled;
  logic                  sign_bit;

  // Per-lane steering; beat 1 carries the bytes that spill past the last lane.
  always_comb begin
    offset    = int'(off);
    nbytes    = 1 << int'(size);
    split     = (offset + nbytes) > LANES;
    be0       = '0;
    be1       = '0;
    wdata0    = '0;
    wdata1    = '0;
    assembled = '0;
    load_data = '0;
    sign_bit  = 1'b0;
    src       = 0;
    for (int i = 0; i < LANES; i++) begin
      be0[i] = (i >= offset) && (i < offset + nbytes);
      be1[i] = split && (i < offset + nbytes - LANES);
      if (i >= offset) begin
        wdata0[8*i +: 8] = wdata[8*(i-offset) +: 8];
      end
      if (i < offset) begin
        wdata1[8*i +: 8] = wdata[8*(i+LANES-offset) +: 8];
      end
      src = i + offset;
      if (src < LANES) begin
        assembled[8*i +: 8] = rdata0[8*src +: 8];
      end else begin
        assembled[8*i +: 8] = rdata1[8*(src-LANES) +: 8];
      end
      if (i == nbytes - 1) begin
        sign_bit = assembled[8*i+7];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (i < nbytes) begin
        load_data[8*i +: 8] = assembled[8*i +: 8];
      end else begin
        load_data[8*i +: 8] = {8{sign_ext & sign_bit}};
      end
    end
  end

endmodule

// File: rtl/execute_load_store.sv
// Sequential load/store unit: one micro-op at a time, up to two memory
// beats for lane-crossing accesses, tagged result on a valid/ready port.
module execute_load_store
  import execute_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_op,
  input  logic [1:0]              in_size,
  input  logic                    in_sign_ext,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_fault
);

  localparam int LANES = lanes_of(DATA_WIDTH);
  localparam int OFF_W = $clog2(LANES);

  lsu_state_t            state_q, state_d;
  op_t                   op_q, op_d;
  size_t                 size_q, size_d;
  logic                  sign_ext_q, sign_ext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  split;
  logic [LANES-1:0]      be0, be1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, load_data, align_rdata0;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  in_beat;

  // In BEAT0 the live read data is the first word; in BEAT1 it is the held copy.
  assign align_rdata0 = (state_q == BEAT0) ? mem_rdata : rdata0_q;

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .off      (addr_q[OFF_W-1:0]),
    .size     (size_q),
    .sign_ext (sign_ext_q),
    .wdata    (data_q),
    .rdata0   (align_rdata0),
    .rdata1   (mem_rdata),
    .split    (split),
    .be0      (be0),
    .be1      (be1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .load_data(load_data)
  );

  // Next-state and datapath capture for the IDLE/BEAT0/BEAT1/RESP sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    rdata0_d   = rdata0_q;
    fault_d    = fault_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = op_t'(in_op);
          size_d     = size_t'(in_size);
          sign_ext_d = in_sign_ext;
          addr_d     = in_address;
          data_d     = in_data;
          tag_d      = in_tag;
          fault_d    = 1'b0;
          out_data_d = '0;
          if ((in_size == 2'd3) && (DATA_WIDTH == 32)) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          rdata0_d = mem_rdata;
          if (mem_err) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else if (split) begin
            state_d = BEAT1;
          end else begin
            out_data_d = (op_q == OP_LOAD) ? load_data : '0;
            state_d    = RESP;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          if (mem_err) begin
            fault_d = 1'b1;
          end else begin
            out_data_d = (op_q == OP_LOAD) ? load_data : '0;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched micro-op registers; reset abandons any in-flight beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      size_q     <= SIZE_B;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      rdata0_q   <= '0;
      fault_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      rdata0_q   <= rdata0_d;
      fault_q    <= fault_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_beat      = (state_q == BEAT0) || (state_q == BEAT1);
  assign aligned_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = in_beat;
  assign mem_we    = in_beat && (op_q == OP_STOR);
  assign mem_addr  = (state_q == BEAT1) ? aligned_addr + ADDR_WIDTH'(LANES) :
                     (state_q == BEAT0) ? aligned_addr : '0;
  assign mem_be    = (state_q == BEAT0) ? be0 : (state_q == BEAT1) ? be1 : '0;
  assign mem_wdata = (state_q == BEAT0) ? wdata0 : (state_q == BEAT1) ? wdata1 : '0;
  assign out_valid = (state_q == RESP);
  assign out_data  = out_data_q;
  assign out_tag   = tag_q;
  assign out_fault = fault_q;

endmodule

// File: tb/tb_execute_load_store.sv
// Directed bench for execute_load_store with hand-computed expectations.
module tb_execute_load_store;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [1:0]  in_size;
  logic        in_sign_ext;
  logic [31:0] in_address;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_fault;

  int checks = 0;
  int errors = 0;

  execute_load_store #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TAG_WIDTH (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_size    (in_size),
    .in_sign_ext(in_sign_ext),
    .in_address (in_address),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_fault  (out_fault)
  );

  // 10-time-unit clock; inputs change and outputs are sampled on negedges.
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one micro-op for a single cycle; on return the unit is in its first post-accept cycle.
  task automatic apply_stimulus(input logic op, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] tag);
    in_valid    = 1'b1;
    in_op       = op;
    in_size     = size;
    in_sign_ext = sext;
    in_address  = addr;
    in_data     = data;
    in_tag      = tag;
    check_output("in_ready_before_accept", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Acknowledge the current beat for one cycle.
  task automatic mem_beat(input logic [31:0] rdata, input logic err);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    mem_err   = err;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 0; in_op = 0; in_size = 0; in_sign_ext = 0;
    in_address = 0; in_data = 0; in_tag = 0; mem_ack = 0; mem_rdata = 0;
    mem_err = 0; out_ready = 1;

    @(negedge clock);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Aligned dword load.
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h1);
    check_output("ld_d_req", mem_req, 1);
    check_output("ld_d_we", mem_we, 0);
    check_output("ld_d_addr", mem_addr, 32'h100);
    check_output("ld_d_be", mem_be, 4'b1111);
    check_output("ld_d_in_ready", in_ready, 0);
    mem_beat(32'h8899AABB, 1'b0);
    check_output("ld_d_valid_c2", out_valid, 1);
    check_output("ld_d_data", out_data, 32'h8899AABB);
    check_output("ld_d_tag", out_tag, 4'h1);
    check_output("ld_d_fault", out_fault, 0);
    @(negedge clock);
    check_output("ld_d_back_idle", in_ready, 1);

    // Byte load, sign extended then zero extended.
    apply_stimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 4'h2);
    check_output("ld_b_be", mem_be, 4'b1000);
    check_output("ld_b_addr", mem_addr, 32'h100);
    mem_beat(32'h80000000, 1'b0);
    check_output("ld_b_sext", out_data, 32'hFFFFFF80);
    @(negedge clock);
    apply_stimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 4'h3);
    mem_beat(32'h80000000, 1'b0);
    check_output("ld_b_zext", out_data, 32'h00000080);
    check_output("ld_b_zext_tag", out_tag, 4'h3);
    @(negedge clock);

    // Split dword store.
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h102, 32'hDDCCBBAA, 4'h4);
    check_output("st_b0_we", mem_we, 1);
    check_output("st_b0_addr", mem_addr, 32'h100);
    check_output("st_b0_be", mem_be, 4'b1100);
    check_output("st_b0_wdata", mem_wdata, 32'hBBAA0000);
    mem_beat(32'h0, 1'b0);
    check_output("st_b1_req", mem_req, 1);
    check_output("st_b1_we", mem_we, 1);
    check_output("st_b1_addr", mem_addr, 32'h104);
    check_output("st_b1_be", mem_be, 4'b0011);
    check_output("st_b1_wdata", mem_wdata, 32'h0000DDCC);
    mem_beat(32'h0, 1'b0);
    check_output("st_valid", out_valid, 1);
    check_output("st_fault", out_fault, 0);
    check_output("st_data", out_data, 0);
    @(negedge clock);

    // Split word load faulting on the first beat.
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 4'h5);
    check_output("err_be", mem_be, 4'b1000);
    mem_beat(32'hFFFFFFFF, 1'b1);
    check_output("err_no_beat1", mem_req, 0);
    check_output("err_valid", out_valid, 1);
    check_output("err_fault", out_fault, 1);
    check_output("err_data", out_data, 0);
    @(negedge clock);

    // Illegal size on a 32-bit datapath: no memory access.
    apply_stimulus(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 4'h6);
    check_output("ill_no_req", mem_req, 0);
    check_output("ill_valid", out_valid, 1);
    check_output("ill_fault", out_fault, 1);
    check_output("ill_tag", out_tag, 4'h6);
    @(negedge clock);

    // Split dword load wrapping around the top of the address space.
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 4'h7);
    check_output("wrap_b0_addr", mem_addr, 32'hFFFFFFFC);
    mem_beat(32'h22110000, 1'b0);
    check_output("wrap_b1_addr", mem_addr, 32'h00000000);
    check_output("wrap_b1_be", mem_be, 4'b0011);
    mem_beat(32'h00004433, 1'b0);
    check_output("wrap_data", out_data, 32'h44332211);
    check_output("wrap_fault", out_fault, 0);
    @(negedge clock);

    // Delayed ack and back-pressured response.
    apply_stimulus(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 4'h8);
    for (int i = 0; i < 3; i++) begin
      check_output("wait_req", mem_req, 1);
      check_output("wait_addr", mem_addr, 32'h100);
      check_output("wait_be", mem_be, 4'b0010);
      check_output("wait_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b0;
    mem_beat(32'h00005A00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_output("bp_valid", out_valid, 1);
      check_output("bp_data", out_data, 32'h5A);
      check_output("bp_tag", out_tag, 4'h8);
      check_output("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    check_output("bp_done_valid", out_valid, 0);
    check_output("bp_done_ready", in_ready, 1);

    // Reset asserted during the second beat of a split load.
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 4'h9);
    mem_beat(32'hAB000000, 1'b0);
    check_output("rb_b1_addr", mem_addr, 32'h104);
    check_output("rb_b1_be", mem_be, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    check_output("rb_req_drop", mem_req, 0);
    check_output("rb_valid_low", out_valid, 0);
    check_output("rb_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    apply_stimulus(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 4'hA);
    mem_beat(32'hAB000000, 1'b0);
    mem_beat(32'h000000CD, 1'b0);
    check_output("rb_next_valid", out_valid, 1);
    check_output("rb_next_data", out_data, 32'hFFFFCDAB);
    check_output("rb_next_tag", out_tag, 4'hA);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
